// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the register-file write-port arbiter signals.
// Handshake: a long-latency result moves on a rising edge of Clk when
// lu_valid and lu_ready are both high in the cycle before it. lu_ready never
// depends on lu_valid. The pipeline writeback stream has no handshake and is
// never backpressured; it is ignored only during a stall_pipe cycle.
interface regfile_wb_arbiter_if;
    // pipeline writeback stream
    logic        pipe_wen;
    logic [4:0]  pipe_rw;
    logic [31:0] pipe_wdata;
    // long-latency result stream
    logic        lu_valid;
    logic [4:0]  lu_rw;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    // long-latency issue and decode hazard check
    logic        iss_valid;
    logic [4:0]  iss_rw;
    logic [4:0]  chk_rx;
    logic [4:0]  chk_ry;
    logic        hazard;
    logic        stall_pipe;
    logic [31:0] pending;
    // register file write port
    logic        rf_wen;
    logic [4:0]  rf_rw;
    logic [31:0] rf_busw;

    // environment side: drives the streams, observes the arbiter results
    modport master (
        output pipe_wen, pipe_rw, pipe_wdata,
        output lu_valid, lu_rw, lu_wdata,
        output iss_valid, iss_rw, chk_rx, chk_ry,
        input  lu_ready, hazard, stall_pipe, pending,
        input  rf_wen, rf_rw, rf_busw
    );

    // arbiter side
    modport slave (
        input  pipe_wen, pipe_rw, pipe_wdata,
        input  lu_valid, lu_rw, lu_wdata,
        input  iss_valid, iss_rw, chk_rx, chk_ry,
        output lu_ready, hazard, stall_pipe, pending,
        output rf_wen, rf_rw, rf_busw
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter and pending-write scoreboard for the 32 x 32b register
// file. The pipeline writeback always wins the port; a long-latency result
// that is blocked STARVE_LIMIT cycles in a row forces a one-cycle pipeline
// stall, during which it is guaranteed to transfer.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input logic                  Clk,
    input logic                  rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             pipe_eff;
    logic             lu_ready_w;
    logic             lu_xfer;
    logic             lu_blocked;

    logic             rf_wen_q,   rf_wen_nxt;
    logic [4:0]       rf_rw_q,    rf_rw_nxt;
    logic [31:0]      rf_busw_q,  rf_busw_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
    logic             stall_q,    stall_nxt;
    logic [31:0]      pending_q,  pending_nxt;

    // Port ownership: pipeline has priority unless this is a stall cycle.
    always_comb begin
        pipe_eff   = bus.pipe_wen && (bus.pipe_rw != 5'd0) && !stall_q;
        lu_ready_w = !pipe_eff;
        lu_xfer    = bus.lu_valid && lu_ready_w;
        lu_blocked = bus.lu_valid && !lu_ready_w;
    end

    // Next write-port contents; address/data hold when nothing is written.
    always_comb begin
        rf_wen_nxt  = 1'b0;
        rf_rw_nxt   = rf_rw_q;
        rf_busw_nxt = rf_busw_q;
        if (pipe_eff) begin
            rf_wen_nxt  = 1'b1;
            rf_rw_nxt   = bus.pipe_rw;
            rf_busw_nxt = bus.pipe_wdata;
        end else if (lu_xfer && (bus.lu_rw != 5'd0)) begin
            rf_wen_nxt  = 1'b1;
            rf_rw_nxt   = bus.lu_rw;
            rf_busw_nxt = bus.lu_wdata;
        end
    end

    // Starvation counter: the last blocked cycle in a run triggers the stall.
    always_comb begin
        stall_nxt      = 1'b0;
        starve_cnt_nxt = '0;
        if (lu_blocked) begin
            if (starve_cnt == CNT_LAST) begin
                stall_nxt = 1'b1;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt_nxt = starve_cnt + 1'b1;
            end else begin
                starve_cnt_nxt = starve_cnt;
            end
        end
    end

    // Scoreboard: completion clears, issue sets afterwards so set wins.
    always_comb begin
        pending_nxt = pending_q;
        if (lu_xfer) begin
            pending_nxt[bus.lu_rw] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rw != 5'd0)) begin
            pending_nxt[bus.iss_rw] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // State registers; a reset discards any write in flight.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q   <= 1'b0;
            rf_rw_q    <= 5'd0;
            rf_busw_q  <= 32'd0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
            pending_q  <= 32'd0;
        end else begin
            rf_wen_q   <= rf_wen_nxt;
            rf_rw_q    <= rf_rw_nxt;
            rf_busw_q  <= rf_busw_nxt;
            starve_cnt <= starve_cnt_nxt;
            stall_q    <= stall_nxt;
            pending_q  <= pending_nxt;
        end
    end

    // Outputs; hazard looks at the registered bitmap only.
    always_comb begin
        bus.lu_ready   = lu_ready_w;
        bus.rf_wen     = rf_wen_q;
        bus.rf_rw      = rf_rw_q;
        bus.rf_busw    = rf_busw_q;
        bus.stall_pipe = stall_q;
        bus.pending    = pending_q;
        bus.hazard     = ((bus.chk_rx != 5'd0) && pending_q[bus.chk_rx]) ||
                         ((bus.chk_ry != 5'd0) && pending_q[bus.chk_ry]);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the arbiter rules.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic Clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .CNT_W(4)
    ) dut (
        .Clk(Clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    // clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // behavioural model state
    bit          m_wen;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    bit          m_stall;
    int          m_run;
    bit          m_pend[32];
    logic [36:0] exp_q[$];

    function automatic void m_reset();
        m_wen = 0; m_rw = '0; m_busw = '0; m_stall = 0; m_run = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        exp_q.delete();
    endfunction

    function automatic bit m_lu_ready();
        return !(bus.pipe_wen && bus.pipe_rw != 0 && !m_stall);
    endfunction

    function automatic bit m_hazard();
        return (bus.chk_rx != 0 && m_pend[bus.chk_rx]) ||
               (bus.chk_ry != 0 && m_pend[bus.chk_ry]);
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // one clock: evaluate the rules on current inputs, then advance model
    task automatic tick();
        bit rdy, xfer, n_wen, n_stall;
        logic [4:0] n_rw;
        logic [31:0] n_busw;
        int n_run;
        rdy = m_lu_ready();
        xfer = bus.lu_valid && rdy;
        n_wen = 0; n_rw = m_rw; n_busw = m_busw;
        if (!rdy) begin
            n_wen = 1; n_rw = bus.pipe_rw; n_busw = bus.pipe_wdata;
        end else if (xfer && bus.lu_rw != 0) begin
            n_wen = 1; n_rw = bus.lu_rw; n_busw = bus.lu_wdata;
        end
        n_stall = 0; n_run = 0;
        if (bus.lu_valid && !rdy) begin
            n_run = m_run + 1;
            if (n_run == LIMIT) begin
                n_stall = 1; n_run = 0;
            end
        end
        @(posedge Clk);
        if (xfer) m_pend[bus.lu_rw] = 0;
        if (bus.iss_valid && bus.iss_rw != 0) m_pend[bus.iss_rw] = 1;
        m_wen = n_wen; m_rw = n_rw; m_busw = n_busw;
        m_stall = n_stall; m_run = n_run;
        if (n_wen) exp_q.push_back({n_rw, n_busw});
        #1;
    endtask

    task automatic drive_idle();
        bus.pipe_wen = 0; bus.pipe_rw = 0; bus.pipe_wdata = 0;
        bus.lu_valid = 0; bus.lu_rw = 0; bus.lu_wdata = 0;
        bus.iss_valid = 0; bus.iss_rw = 0; bus.chk_rx = 0; bus.chk_ry = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        m_reset();
        repeat (3) @(posedge Clk);
        #1 rst_n = 1;
        #1;
        checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen: got %b want 0", bus.rf_wen); end
        checks++; if (bus.rf_rw !== 5'd0) begin errors++; $display("FAIL reset_rf_rw: got %0d want 0", bus.rf_rw); end
        checks++; if (bus.rf_busw !== 32'd0) begin errors++; $display("FAIL reset_rf_busw: got %h want 0", bus.rf_busw); end
        checks++; if (bus.stall_pipe !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_pipe); end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h want 0", bus.pending); end
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready: got %b want 1", bus.lu_ready); end
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", bus.hazard); end
        tick();
        checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL idle_rf_wen: got %b want 0", bus.rf_wen); end
    endtask

    task automatic test_primary();
        bus.pipe_wen = 1; bus.pipe_rw = 5; bus.pipe_wdata = 32'hDEADBEEF;
        tick();
        checks++; if (bus.rf_wen !== 1'b1) begin errors++; $display("FAIL primary_wen: got %b want 1", bus.rf_wen); end
        checks++; if (bus.rf_rw !== 5'd5) begin errors++; $display("FAIL primary_rw: got %0d want 5", bus.rf_rw); end
        checks++; if (bus.rf_busw !== 32'hDEADBEEF) begin errors++; $display("FAIL primary_busw: got %h want deadbeef", bus.rf_busw); end
        bus.pipe_rw = 0; bus.pipe_wdata = 32'h0BAD0BAD;
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL r0_write_ready: got %b want 1", bus.lu_ready); end
        tick();
        checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL r0_write_wen: got %b want 0", bus.rf_wen); end
        checks++; if (bus.rf_busw !== 32'hDEADBEEF) begin errors++; $display("FAIL r0_write_hold: got %h want deadbeef", bus.rf_busw); end
        drive_idle();
        tick();
    endtask

    task automatic test_contention();
        bus.pipe_wen = 1; bus.pipe_rw = 3; bus.pipe_wdata = 32'hAAAA0003;
        bus.lu_valid = 1; bus.lu_rw = 7; bus.lu_wdata = 32'h12345678;
        #1;
        checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL contend_ready: got %b want 0", bus.lu_ready); end
        tick();
        checks++; if (bus.rf_rw !== 5'd3 || bus.rf_wen !== 1'b1) begin errors++; $display("FAIL contend_pipe_wins: got wen=%b rw=%0d want wen=1 rw=3", bus.rf_wen, bus.rf_rw); end
        bus.pipe_wen = 0;
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL contend_ready_free: got %b want 1", bus.lu_ready); end
        tick();
        bus.lu_valid = 0;
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rw !== 5'd7 || bus.rf_busw !== 32'h12345678) begin
            errors++; $display("FAIL contend_lu_write: got wen=%b rw=%0d data=%h want 1/7/12345678", bus.rf_wen, bus.rf_rw, bus.rf_busw);
        end
        tick();
    endtask

    task automatic test_starvation();
        drive_idle();
        tick();
        bus.pipe_wen = 1; bus.pipe_rw = 4; bus.pipe_wdata = 32'h44444444;
        bus.lu_valid = 1; bus.lu_rw = 7; bus.lu_wdata = 32'hCAFEF00D;
        for (int c = 1; c <= LIMIT - 1; c++) begin
            tick();
            checks++; if (bus.stall_pipe !== 1'b0) begin errors++; $display("FAIL starve_early_stall c%0d: got %b want 0", c, bus.stall_pipe); end
        end
        tick();
        checks++; if (bus.stall_pipe !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", bus.stall_pipe); end
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL starve_ready: got %b want 1", bus.lu_ready); end
        tick();
        bus.lu_valid = 0;
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rw !== 5'd7 || bus.rf_busw !== 32'hCAFEF00D) begin
            errors++; $display("FAIL starve_lu_write: got wen=%b rw=%0d data=%h want 1/7/cafef00d", bus.rf_wen, bus.rf_rw, bus.rf_busw);
        end
        checks++; if (bus.stall_pipe !== 1'b0) begin errors++; $display("FAIL starve_stall_once: got %b want 0", bus.stall_pipe); end
        drive_idle();
        tick();
    endtask

    task automatic test_scoreboard();
        bus.iss_valid = 1; bus.iss_rw = 9;
        tick();
        bus.iss_valid = 0; bus.chk_rx = 9;
        #1;
        checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_rx: got %b want 1", bus.hazard); end
        bus.chk_rx = 2; bus.chk_ry = 9;
        #1;
        checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_ry: got %b want 1", bus.hazard); end
        bus.lu_valid = 1; bus.lu_rw = 9; bus.lu_wdata = 32'h99;
        #1;
        checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_same_cycle: got %b want 1", bus.hazard); end
        tick();
        bus.lu_valid = 0;
        #1;
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL sb_hazard_cleared: got %b want 0", bus.hazard); end
        bus.iss_valid = 1; bus.iss_rw = 9;
        tick();
        bus.lu_valid = 1; bus.lu_rw = 9;
        tick();
        bus.iss_valid = 0; bus.lu_valid = 0;
        checks++; if (bus.pending !== 32'h0000_0200) begin errors++; $display("FAIL sb_set_wins: got %h want 00000200", bus.pending); end
        bus.lu_valid = 1;
        tick();
        bus.lu_valid = 0; bus.iss_valid = 1; bus.iss_rw = 0;
        tick();
        bus.iss_valid = 0;
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL sb_issue_r0: got %h want 0", bus.pending); end
        drive_idle();
    endtask

    task automatic test_r0_read();
        bus.iss_valid = 1;
        for (int r = 1; r < 32; r += 3) begin
            bus.iss_rw = 5'(r);
            tick();
        end
        bus.iss_valid = 0; bus.chk_rx = 0; bus.chk_ry = 0;
        #1;
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL r0_read_hazard: got %b want 0 pend=%h", bus.hazard, bus.pending); end
        checks++; if (bus.pending !== m_pend_vec()) begin errors++; $display("FAIL r0_read_pending: got %h want %h", bus.pending, m_pend_vec()); end
    endtask

    task automatic test_reset_mid();
        bus.pipe_wen = 1; bus.pipe_rw = 12; bus.pipe_wdata = 32'h5A5A5A5A;
        tick();
        bus.pipe_wen = 0;
        checks++; if (bus.rf_wen !== 1'b1) begin errors++; $display("FAIL rstmid_pre_wen: got %b want 1", bus.rf_wen); end
        rst_n = 0;
        m_reset();
        #1;
        checks++; if (bus.rf_wen !== 1'b0 || bus.rf_rw !== 5'd0 || bus.rf_busw !== 32'd0) begin
            errors++; $display("FAIL rstmid_async: got wen=%b rw=%0d data=%h want 0/0/0", bus.rf_wen, bus.rf_rw, bus.rf_busw);
        end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL rstmid_pending: got %h want 0", bus.pending); end
        drive_idle();
        @(posedge Clk);
        #1 rst_n = 1;
        #1;
    endtask

    task automatic test_random();
        exp_q.delete();
        for (int n = 0; n < 600; n++) begin
            bus.pipe_wen   = ($urandom_range(0, 99) < 75);
            bus.pipe_rw    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.pipe_wdata = $urandom;
            bus.lu_valid   = ($urandom_range(0, 99) < 60);
            bus.lu_rw      = 5'($urandom_range(0, 31));
            bus.lu_wdata   = $urandom;
            bus.iss_valid  = ($urandom_range(0, 99) < 30);
            bus.iss_rw     = 5'($urandom_range(0, 31));
            bus.chk_rx     = 5'($urandom_range(0, 31));
            bus.chk_ry     = 5'($urandom_range(0, 31));
            #1;
            checks++; if (bus.lu_ready !== m_lu_ready()) begin errors++; $display("FAIL rnd_lu_ready n%0d: got %b want %b", n, bus.lu_ready, m_lu_ready()); end
            checks++; if (bus.hazard !== m_hazard()) begin errors++; $display("FAIL rnd_hazard n%0d: got %b want %b", n, bus.hazard, m_hazard()); end
            tick();
            checks++; if (bus.rf_wen !== m_wen) begin errors++; $display("FAIL rnd_rf_wen n%0d: got %b want %b", n, bus.rf_wen, m_wen); end
            checks++; if (bus.rf_rw !== m_rw || bus.rf_busw !== m_busw) begin
                errors++; $display("FAIL rnd_rf_port n%0d: got %0d/%h want %0d/%h", n, bus.rf_rw, bus.rf_busw, m_rw, m_busw);
            end
            checks++; if (bus.stall_pipe !== m_stall) begin errors++; $display("FAIL rnd_stall n%0d: got %b want %b", n, bus.stall_pipe, m_stall); end
            checks++; if (bus.pending !== m_pend_vec()) begin errors++; $display("FAIL rnd_pending n%0d: got %h want %h", n, bus.pending, m_pend_vec()); end
            if (bus.rf_wen === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_write_unexpected n%0d: got %0d/%h want none", n, bus.rf_rw, bus.rf_busw);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    if ({bus.rf_rw, bus.rf_busw} !== e) begin
                        errors++; $display("FAIL rnd_write_order n%0d: got %h want %h", n, {bus.rf_rw, bus.rf_busw}, e);
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_write_missing: got %0d left want 0", exp_q.size()); end
        drive_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        test_reset();
        test_primary();
        test_contention();
        test_starvation();
        test_scoreboard();
        test_r0_read();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
